// File: rtl/axis_ins_pkg.sv
// rtl/axis_ins_pkg.sv - shared state type and keep helpers for the AXIS header inserter
package axis_ins_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // n ones aligned to the MSB of a w-bit keep vector (w <= 64), returned right-justified
  function automatic logic [63:0] keep_ones(input int unsigned n, input int unsigned w);
    return ((64'd1 << n) - 64'd1) << (w - n);
  endfunction

  function automatic int unsigned byte_cnt(input logic [63:0] keep);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) c += int'(keep[i]);
    return c;
  endfunction

endpackage

// File: rtl/axis_keep_cnt.sv
// rtl/axis_keep_cnt.sv - keep vector to byte count plus MSB-first contiguity flag
module axis_keep_cnt
  import axis_ins_pkg::*;
#(
  parameter int DATA_BYTE_WD = 4,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic [DATA_BYTE_WD-1:0] keep,
  output logic [BYTE_CNT_WD:0]    cnt,
  output logic                    contig
);

  int unsigned w_ones;

  always_comb begin
    w_ones = byte_cnt(64'(keep));
    cnt    = (BYTE_CNT_WD+1)'(w_ones);
    contig = (keep == DATA_BYTE_WD'(keep_ones(w_ones, DATA_BYTE_WD)));
  end

endmodule

// File: rtl/axis_insert_header_pipe.sv
// rtl/axis_insert_header_pipe.sv - AXIS header inserter, packs 0..DATA_BYTE_WD header bytes ahead of each packet
// Optional sticky keep-error flag: define AXIS_INS_ERR_EN.
module axis_insert_header_pipe
  import axis_ins_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD:0]    byte_insert_cnt,
  output logic                    ready_insert
`ifdef AXIS_INS_ERR_EN
  ,
  output logic                    err_keep
`endif
);

  localparam logic [BYTE_CNT_WD+1:0] FULL = (BYTE_CNT_WD+2)'(DATA_BYTE_WD);

  state_t                   r_state;
  logic [DATA_WD-1:0]       r_res;
  logic [BYTE_CNT_WD:0]     r_res_cnt;

  logic                     w_adv;
  logic                     w_xfer_in;
  logic [BYTE_CNT_WD:0]     w_n;
  logic                     w_contig;
  logic [BYTE_CNT_WD+1:0]   w_tot;
  logic [BYTE_CNT_WD:0]     w_ovf_cnt;
  logic [DATA_WD-1:0]       w_din;
  logic [2*DATA_WD-1:0]     w_cat;
  logic [BYTE_CNT_WD+3:0]   w_res_sh;
  logic [BYTE_CNT_WD+3:0]   w_hdr_sh;
  logic                     w_unused_ins;

  axis_keep_cnt #(
    .DATA_BYTE_WD(DATA_BYTE_WD),
    .BYTE_CNT_WD (BYTE_CNT_WD)
  ) u_keep_cnt (
    .keep  (keep_in),
    .cnt   (w_n),
    .contig(w_contig)
  );

  assign w_adv        = !valid_out || ready_out;
  assign ready_insert = (r_state == IDLE);
  assign ready_in     = (r_state == STREAM) && w_adv;
  assign w_xfer_in    = valid_in && ready_in;
  assign w_tot        = {1'b0, r_res_cnt} + {1'b0, w_n};
  assign w_ovf_cnt    = (BYTE_CNT_WD+1)'(w_tot - FULL);
  assign w_res_sh     = {r_res_cnt, 3'b000};
  assign w_hdr_sh     = {(BYTE_CNT_WD+1)'(DATA_BYTE_WD) - byte_insert_cnt, 3'b000};
  assign w_unused_ins = ^keep_insert;

  // Unkept payload bytes are zeroed so partial beats and residues come out zero-filled
  always_comb begin
    w_din = '0;
    for (int b = 0; b < DATA_BYTE_WD; b++) begin
      if (keep_in[b]) w_din[b*8 +: 8] = data_in[b*8 +: 8];
    end
  end

  // Residue occupies the top r_res_cnt bytes; payload slides in right behind it
  assign w_cat = {r_res, {DATA_WD{1'b0}}} | ({w_din, {DATA_WD{1'b0}}} >> w_res_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_res     <= '0;
      r_res_cnt <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      if (w_adv) valid_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid_insert) begin
            r_res     <= data_insert << w_hdr_sh;
            r_res_cnt <= byte_insert_cnt;
            r_state   <= STREAM;
          end
        end
        STREAM: begin
          if (w_xfer_in) begin
            valid_out <= 1'b1;
            data_out  <= w_cat[2*DATA_WD-1 -: DATA_WD];
            if (!last_in) begin
              keep_out  <= '1;
              last_out  <= 1'b0;
              r_res     <= w_cat[DATA_WD-1:0];
              r_res_cnt <= (w_tot > FULL) ? w_ovf_cnt : '0;
            end else if (w_tot <= FULL) begin
              keep_out <= DATA_BYTE_WD'(keep_ones(int'(w_tot), DATA_BYTE_WD));
              last_out <= 1'b1;
              r_state  <= IDLE;
            end else begin
              keep_out  <= '1;
              last_out  <= 1'b0;
              r_res     <= w_cat[DATA_WD-1:0];
              r_res_cnt <= w_ovf_cnt;
              r_state   <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (w_adv) begin
            valid_out <= 1'b1;
            data_out  <= r_res;
            keep_out  <= DATA_BYTE_WD'(keep_ones(int'(r_res_cnt), DATA_BYTE_WD));
            last_out  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_INS_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_keep <= 1'b0;
    end else if (w_xfer_in && (!w_contig || (!last_in && keep_in != '1))) begin
      err_keep <= 1'b1;
    end
  end
`else
  logic w_unused_contig;
  assign w_unused_contig = w_contig;
`endif

endmodule

// File: tb/tb_axis_insert_header_pipe.sv
// tb/tb_axis_insert_header_pipe.sv - table-driven scoreboard bench for axis_insert_header_pipe
module tb_axis_insert_header_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_insert, ready_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic [2:0]  byte_insert_cnt;
`ifdef AXIS_INS_ERR_EN
  logic        err_keep;
`endif

  always #5 clk = ~clk;

  axis_insert_header_pipe #(.DATA_WD(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out),
    .valid_insert   (valid_insert),
    .data_insert    (data_insert),
    .keep_insert    (keep_insert),
    .byte_insert_cnt(byte_insert_cnt),
    .ready_insert   (ready_insert)
`ifdef AXIS_INS_ERR_EN
    ,
    .err_keep       (err_keep)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [31:0]       hdr;
    logic [2:0]        cnt;
    logic              tgl;
    logic [1:0]        nin;
    logic [2:0][31:0]  din;
    logic [2:0][3:0]   kin;
    logic [2:0]        nout;
    logic [3:0][31:0]  dout;
    logic [3:0][3:0]   kout;
  } vec_t;

  vec_t  tbl[10];
  int    n_vec = 0;
  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail = 0;
  logic  tgl = 1'b0;
  logic  mon_en = 1'b0;
  logic  hold_v = 1'b0;
  beat_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] hdr, input logic [2:0] cnt, input logic t);
    tbl[n_vec] = '0;
    tbl[n_vec].hdr = hdr;
    tbl[n_vec].cnt = cnt;
    tbl[n_vec].tgl = t;
    n_vec++;
  endtask

  task automatic add_in(input logic [31:0] d, input logic [3:0] k);
    tbl[n_vec-1].din[tbl[n_vec-1].nin] = d;
    tbl[n_vec-1].kin[tbl[n_vec-1].nin] = k;
    tbl[n_vec-1].nin = tbl[n_vec-1].nin + 2'd1;
  endtask

  task automatic add_out(input logic [31:0] d, input logic [3:0] k);
    tbl[n_vec-1].dout[tbl[n_vec-1].nout[1:0]] = d;
    tbl[n_vec-1].kout[tbl[n_vec-1].nout[1:0]] = k;
    tbl[n_vec-1].nout = tbl[n_vec-1].nout + 3'd1;
  endtask

  // Downstream ready: constant high, or toggling every cycle when tgl is set
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = tgl ? ~ready_out : 1'b1;
    end
  end

  // Scoreboard pop on each output transfer plus hold-stability check during stalls
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v && valid_out)
          check("stall_stable", 64'({data_out, keep_out, last_out}), 64'(held));
        if (valid_out && ready_out) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_beat: got %h%h%b expected none", data_out, keep_out, last_out);
          end else begin
            check("beat", 64'({data_out, keep_out, last_out}), 64'(sb.pop_front()));
          end
        end
        hold_v = valid_out && !ready_out;
        held = {data_out, keep_out, last_out};
      end
    end
  end

  task automatic send_hdr(input logic [31:0] d, input logic [2:0] c);
    int t;
    t = 0;
    valid_insert = 1'b1;
    data_insert = d;
    byte_insert_cnt = c;
    keep_insert = 4'hF;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_insert && t < 200);
    if (!ready_insert) begin
      n_tests++;
      n_fail++;
      $display("FAIL hdr_timeout: got ready_insert=0 expected 1");
    end
    @(posedge clk);
    #1;
    valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t;
    t = 0;
    valid_in = 1'b1;
    data_in = d;
    keep_in = k;
    last_in = l;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_in && t < 200);
    if (!ready_in) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: got ready_in=0 expected 1");
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int t;
    tgl = tbl[i].tgl;
    for (int j = 0; j < int'(tbl[i].nout); j++)
      sb.push_back({tbl[i].dout[j], tbl[i].kout[j], (j == int'(tbl[i].nout) - 1)});
    send_hdr(tbl[i].hdr, tbl[i].cnt);
    for (int j = 0; j < int'(tbl[i].nin); j++)
      send_beat(tbl[i].din[j], tbl[i].kin[j], (j == int'(tbl[i].nin) - 1));
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    tgl = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid_out"}, 64'(valid_out), 64'd0);
    check({tag, "_last_out"}, 64'(last_out), 64'd0);
    check({tag, "_keep_out"}, 64'(keep_out), 64'd0);
    check({tag, "_data_out"}, 64'(data_out), 64'd0);
    check({tag, "_ready_in"}, 64'(ready_in), 64'd0);
    check({tag, "_ready_insert"}, 64'(ready_insert), 64'd1);
  endtask

  initial begin
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;

    add_vec(32'hAABBCCDD, 3'd2, 1'b0);
    add_in(32'h11223344, 4'hF); add_in(32'h55667788, 4'hF); add_in(32'h99AA0000, 4'hC);
    add_out(32'hCCDD1122, 4'hF); add_out(32'h33445566, 4'hF); add_out(32'h778899AA, 4'hF);
    add_vec(32'hAABBCCDD, 3'd2, 1'b0);
    add_in(32'h11223344, 4'hF); add_in(32'h55667788, 4'hF); add_in(32'h99AABB00, 4'hE);
    add_out(32'hCCDD1122, 4'hF); add_out(32'h33445566, 4'hF); add_out(32'h778899AA, 4'hF);
    add_out(32'hBB000000, 4'h8);
    add_vec(32'h12345678, 3'd0, 1'b0);
    add_in(32'h01020304, 4'hF); add_in(32'h05060000, 4'hC);
    add_out(32'h01020304, 4'hF); add_out(32'h05060000, 4'hC);
    add_vec(32'hDEADBEEF, 3'd4, 1'b0);
    add_in(32'h12000000, 4'h8);
    add_out(32'hDEADBEEF, 4'hF); add_out(32'h12000000, 4'h8);
    add_vec(32'hAABBCCDD, 3'd2, 1'b1);
    add_in(32'h11223344, 4'hF); add_in(32'h55667788, 4'hF); add_in(32'h99AA0000, 4'hC);
    add_out(32'hCCDD1122, 4'hF); add_out(32'h33445566, 4'hF); add_out(32'h778899AA, 4'hF);
    add_vec(32'h00000000, 3'd0, 1'b0);
    add_in(32'h00000000, 4'h0);
    add_out(32'h00000000, 4'h0);
    add_vec(32'hFFFFFF55, 3'd1, 1'b0);
    add_in(32'h01020304, 4'hF);
    add_out(32'h55010203, 4'hF); add_out(32'h04000000, 4'h8);
    add_vec(32'h00A1B2C3, 3'd3, 1'b1);
    add_in(32'hAABBCCDD, 4'hF); add_in(32'hEE000000, 4'h8);
    add_out(32'hA1B2C3AA, 4'hF); add_out(32'hBBCCDDEE, 4'hF);

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < n_vec; i++) run_vec(i);

    mon_en = 1'b0;
    send_hdr(32'hAABBCCDD, 3'd2);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h55667788, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    run_vec(1);

`ifdef AXIS_INS_ERR_EN
    check("err_clear", 64'(err_keep), 64'd0);
    mon_en = 1'b0;
    send_hdr(32'h0, 3'd0);
    send_beat(32'h11223344, 4'hB, 1'b1);
    check("err_set", 64'(err_keep), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 64'(err_keep), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
